handshake_rr_arbiter: RTL and testbench
=======================================

// Module: handshake_rr_arbiter
// PURPOSE
//  - Shares one registered valid/ready output stage among NUM_PORTS requesters.
//  - Uses round-robin arbitration and holds the grant for the length of a multi-beat burst.
//  - Sits in front of a downstream consumer that accepts one stream at a time.
//  - Tags every output beat with its source index.
// PARAMETERS
//  - NUM_PORTS   4  number of requesters, >= 2; non-power-of-two values are legal.
//  - VALUE_BITS  8  payload width per beat.
//  - INDEX_BITS  derived (localparam), = max(1, $clog2(NUM_PORTS)).
// PORTS
//  - clock    in   1                       rising-edge clock.
//  - reset_n  in   1                       asynchronous, active-low reset.
//  - i_value  in   NUM_PORTS x VALUE_BITS  per-requester payload, packed [NUM_PORTS-1:0][VALUE_BITS-1:0].
//  - i_last   in   NUM_PORTS               per-requester end-of-burst flag, qualified by i_valid.
//  - i_valid  in   NUM_PORTS               per-requester valid.
//  - o_ready  out  NUM_PORTS               per-requester ready; combinational; at most one bit set.
//  - o_value  out  VALUE_BITS              registered payload.
//  - o_index  out  INDEX_BITS              registered source index of o_value.
//  - o_last   out  1                       registered end-of-burst flag.
//  - o_valid  out  1                       registered valid.
//  - i_ready  in   1                       downstream ready.
// BEHAVIOUR
//  - Reset: o_valid=0, o_value=0, o_index=0, o_last=0, rr_ptr=0, state=IDLE. Reset is legal mid-burst:
//    the lock is dropped and any pending output beat is discarded.
//  - Stage ready: stage_rdy = ~o_valid | i_ready. The stage loads on stage_rdy.
//    A full stage with i_ready=1 is emptied and reloaded in the same cycle, sustaining one beat per clock.
//  - Grant g, combinational:
//      IDLE:   first k in rr_ptr, rr_ptr+1, ... (mod NUM_PORTS) with i_valid[k]=1.
//      LOCKED: g = lock_idx, with or without i_valid[lock_idx].
//  - o_ready[k] = stage_rdy & (k==g) & (state==LOCKED | i_valid[k]).
//    When no request is pending in IDLE, o_ready is all 0.
//  - Beat transfer: xfer = i_valid[g] & o_ready[g]. On xfer the stage loads
//    o_value=i_value[g], o_index=g, o_last=i_last[g], o_valid=1.
//  - When stage_rdy=1 and there is no xfer, o_valid<=0; o_value, o_index and o_last hold.
//  - State machine:
//      IDLE   -> LOCKED  on xfer with i_last[g]=0; lock_idx<=g.
//      IDLE   -> IDLE    on xfer with i_last[g]=1, or on no xfer.
//      LOCKED -> IDLE    on xfer with i_last[lock_idx]=1.
//      LOCKED -> LOCKED  otherwise, including when the locked requester drops i_valid (a gap);
//                        the other requesters stay blocked.
//  - Pointer update: rr_ptr<=g+1 on the first beat of a grant (xfer while IDLE) only.
//    NUM_PORTS-1 wraps to 0. rr_ptr is unchanged during LOCKED.
//  - Latency: one cycle from an accepted input beat to o_valid.
//  - Fairness: each continuously requesting port is granted within NUM_PORTS bursts.
//  - Upstream rule: i_valid/i_value/i_last must not depend combinationally on o_ready.
//    A requester holds its beat stable until o_ready.
//  - Simultaneous requests: the lowest distance from rr_ptr wins. A single requester is granted
//    back-to-back at full rate.
// STRUCTURE
//  - Package handshake_pkg holds typedef enum logic [0:0] {ARB_IDLE, ARB_LOCKED} arb_state_e
//    and function rr_pick(req, ptr) -> index, shared with other arbiters.
//  - One sub-module, handshake_rr_pick: combinational round-robin priority encoder
//    (req vector, ptr -> grant index + any).
//  - The top level holds the FSM, rr_ptr, lock_idx and the output register stage.
// TESTING
//  - Reset mid-burst:
//    port0 sends a 3-beat burst; reset_n pulsed low after beat 1
//    -> all outputs 0, state IDLE, rr_ptr=0; port0 re-arbitrates afterwards.
//  - Simultaneous single beats:
//    all 4 ports valid with single beats (last=1), i_ready=1
//    -> o_index sequence 0,1,2,3,0 on consecutive cycles; values match.
//  - Burst lock:
//    port1 sends a 4-beat burst, port2 valid throughout
//    -> o_index=1 for 4 beats, o_ready[2]=0 until port1's last beat is accepted, then o_index=2.
//  - Backpressure:
//    i_ready=0 for 3 cycles with o_valid=1
//    -> o_value/o_index/o_last stable, all o_ready=0; i_ready=1 then yields one beat per cycle.
//  - Pointer wrap, non-power-of-two NUM_PORTS:
//    NUM_PORTS=3, only port2 and port0 request
//    -> grants alternate 2,0,2,0; rr_ptr wraps 2->0.
//  - Gap inside a lock:
//    locked port3 drops i_valid for 2 cycles, port0 valid
//    -> o_valid falls, port0 stays blocked, and the burst resumes with o_index=3.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared arbitration types and the round-robin pick helper used by the
// handshake arbiters.
package handshake_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Widest request vector rr_pick can scan; callers zero-extend into it.
  localparam int MAX_PORTS = 32;

  // First requester at or after ptr, wrapping at num. Returns ptr when
  // nothing is requesting, so callers must qualify with |req.
  function automatic int rr_pick(input logic [MAX_PORTS-1:0] req,
                                 input int num, input int ptr);
    int   pick;
    int   k;
    logic found;
    pick  = ptr;
    found = 1'b0;
    for (int d = 0; d < MAX_PORTS; d++) begin
      if (d < num) begin
        k = ptr + d;
        if (k >= num) k = k - num;
        if (!found && req[k]) begin
          pick  = k;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/handshake_rr_pick.sv
// Combinational round-robin priority encoder: the nearest active request at or
// after ptr_i wins.
module handshake_rr_pick
  import handshake_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int INDEX_BITS = 2
) (
  input  logic [NUM_PORTS-1:0]  req_i,
  input  logic [INDEX_BITS-1:0] ptr_i,
  output logic [INDEX_BITS-1:0] grant_o,
  output logic                  any_o
);

  logic [MAX_PORTS-1:0] req_ext;

  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_PORTS-1:0]   = req_i;
    grant_o = INDEX_BITS'(rr_pick(req_ext, NUM_PORTS, int'(ptr_i)));
    any_o   = |req_i;
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready stage; a grant is held
// for the whole burst and each output beat carries its source index.
module handshake_rr_arbiter
  import handshake_pkg::*;
#(
  parameter  int NUM_PORTS  = 4,
  parameter  int VALUE_BITS = 8,
  localparam int INDEX_BITS = (NUM_PORTS <= 2) ? 1 : $clog2(NUM_PORTS)
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [NUM_PORTS-1:0][VALUE_BITS-1:0] i_value,
  input  logic [NUM_PORTS-1:0]                 i_last,
  input  logic [NUM_PORTS-1:0]                 i_valid,
  output logic [NUM_PORTS-1:0]                 o_ready,
  output logic [VALUE_BITS-1:0]                o_value,
  output logic [INDEX_BITS-1:0]                o_index,
  output logic                                 o_last,
  output logic                                 o_valid,
  input  logic                                 i_ready
);

  arb_state_e              state_q, state_d;
  logic [INDEX_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [INDEX_BITS-1:0]   lock_idx_q, lock_idx_d;
  logic [VALUE_BITS-1:0]   value_q, value_d;
  logic [INDEX_BITS-1:0]   index_q, index_d;
  logic                    last_q, last_d;
  logic                    valid_q, valid_d;

  logic [INDEX_BITS-1:0]   pick_idx;
  logic                    pick_any;
  logic [INDEX_BITS-1:0]   grant;
  logic [INDEX_BITS-1:0]   ptr_next;
  logic                    locked;
  logic                    grant_live;
  logic                    stage_rdy;
  logic                    xfer;

  handshake_rr_pick #(
    .NUM_PORTS  (NUM_PORTS),
    .INDEX_BITS (INDEX_BITS)
  ) u_pick (
    .req_i   (i_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_idx),
    .any_o   (pick_any)
  );

  assign locked     = (state_q == ARB_LOCKED);
  assign stage_rdy  = ~valid_q | i_ready;
  assign grant      = locked ? lock_idx_q : pick_idx;
  // A locked grant stays live through gaps so other requesters remain blocked.
  assign grant_live = locked | pick_any;
  assign xfer       = |(o_ready & i_valid);
  assign ptr_next   = (grant == INDEX_BITS'(NUM_PORTS - 1)) ? '0
                                                             : grant + INDEX_BITS'(1);

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
    assign o_ready[gi] = stage_rdy & grant_live & (grant == INDEX_BITS'(gi));
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    value_d    = value_q;
    index_d    = index_q;
    last_d     = last_q;
    valid_d    = valid_q;

    if (stage_rdy) begin
      if (xfer) begin
        value_d = i_value[grant];
        index_d = grant;
        last_d  = i_last[grant];
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end

    unique case (state_q)
      ARB_IDLE: begin
        if (xfer) begin
          rr_ptr_d = ptr_next;
          if (!i_last[grant]) begin
            state_d    = ARB_LOCKED;
            lock_idx_d = grant;
          end
        end
      end
      ARB_LOCKED: begin
        if (xfer && i_last[grant]) state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      value_q    <= '0;
      index_q    <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      value_q    <= value_d;
      index_q    <= index_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
    end
  end

  assign o_value = value_q;
  assign o_index = index_q;
  assign o_last  = last_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed vector bench for handshake_rr_arbiter: a 4-port instance driven from
// a cycle table plus a 3-port instance for pointer wrap.
module tb_handshake_rr_arbiter;

  logic            clock;
  logic            reset_n;
  logic [3:0][7:0] i_value;
  logic [3:0]      i_last;
  logic [3:0]      i_valid;
  logic [3:0]      o_ready;
  logic [7:0]      o_value;
  logic [1:0]      o_index;
  logic            o_last;
  logic            o_valid;
  logic            i_ready;

  logic [2:0][7:0] v3_value;
  logic [2:0]      v3_last;
  logic [2:0]      v3_valid;
  logic [2:0]      o3_ready;
  logic [7:0]      o3_value;
  logic [1:0]      o3_index;
  logic            o3_last;
  logic            o3_valid;
  logic            v3_ready;

  int checks = 0;
  int passes = 0;

  handshake_rr_arbiter #(.NUM_PORTS(4), .VALUE_BITS(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .i_value (i_value),
    .i_last  (i_last),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_value (o_value),
    .o_index (o_index),
    .o_last  (o_last),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  handshake_rr_arbiter #(.NUM_PORTS(3), .VALUE_BITS(8)) dut3 (
    .clock   (clock),
    .reset_n (reset_n),
    .i_value (v3_value),
    .i_last  (v3_last),
    .i_valid (v3_valid),
    .o_ready (o3_ready),
    .o_value (o3_value),
    .o_index (o3_index),
    .o_last  (o3_last),
    .o_valid (o3_valid),
    .i_ready (v3_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        rdy;
    logic [31:0] vals;
    logic [3:0]  ordy;
    logic        ovalid;
    logic [1:0]  oidx;
    logic [7:0]  oval;
    logic        olast;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] valid, logic [3:0] last, logic rdy,
                              logic [31:0] vals, logic [3:0] ordy, logic ovalid,
                              logic [1:0] oidx, logic [7:0] oval, logic olast);
    vec_t v;
    v.valid = valid; v.last = last; v.rdy = rdy; v.vals = vals;
    v.ordy = ordy; v.ovalid = ovalid; v.oidx = oidx; v.oval = oval; v.olast = olast;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive at the falling edge, check o_ready mid-cycle, registered outputs after the rise.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clock);
    i_valid = v.valid;
    i_last  = v.last;
    i_ready = v.rdy;
    i_value = v.vals;
    #1;
    chk({tag, " o_ready"}, 32'(o_ready), 32'(v.ordy));
    @(posedge clock);
    #1;
    chk({tag, " o_valid"}, 32'(o_valid), 32'(v.ovalid));
    chk({tag, " o_index"}, 32'(o_index), 32'(v.oidx));
    chk({tag, " o_value"}, 32'(o_value), 32'(v.oval));
    chk({tag, " o_last"},  32'(o_last),  32'(v.olast));
    $display("%s: valid=%b ready=%b -> o_valid=%b idx=%0d val=%h last=%b",
             tag, v.valid, o_ready, o_valid, o_index, o_value, o_last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp3_idx[5];
    logic [2:0] exp3_rdy[5];

    reset_n  = 1'b0;
    i_valid  = '0; i_last = '0; i_value = '0; i_ready = 1'b1;
    v3_valid = '0; v3_last = '0; v3_value = '0; v3_ready = 1'b1;
    #3;
    chk("reset o_valid", 32'(o_valid), 32'd0);
    chk("reset o_value", 32'(o_value), 32'd0);
    chk("reset o_index", 32'(o_index), 32'd0);
    chk("reset o_last",  32'(o_last),  32'd0);
    chk("reset o_ready", 32'(o_ready), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Simultaneous single beats: grants 0,1,2,3,0.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(4'b1111, 4'b1111, 1'b1, 32'hA3A2A1A0, 4'b0001 << (i % 4),
                        1'b1, 2'(i % 4), 8'hA0 + 8'(i % 4), 1'b1));
    // Burst lock: port1 four beats, port2 waits.
    vecs.push_back(mk(4'b0110, 4'b0100, 1'b1, 32'h00C0B000, 4'b0010, 1'b1, 2'd1, 8'hB0, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0100, 1'b1, 32'h00C0B100, 4'b0010, 1'b1, 2'd1, 8'hB1, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0100, 1'b1, 32'h00C0B200, 4'b0010, 1'b1, 2'd1, 8'hB2, 1'b0));
    vecs.push_back(mk(4'b0110, 4'b0110, 1'b1, 32'h00C0B300, 4'b0010, 1'b1, 2'd1, 8'hB3, 1'b1));
    vecs.push_back(mk(4'b0100, 4'b0100, 1'b1, 32'h00C00000, 4'b0100, 1'b1, 2'd2, 8'hC0, 1'b1));
    // Backpressure for three cycles, then full rate from a lone requester.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(4'b1000, 4'b1000, 1'b0, 32'hD0000000, 4'b0000, 1'b1, 2'd2, 8'hC0, 1'b1));
    vecs.push_back(mk(4'b1000, 4'b1000, 1'b1, 32'hD0000000, 4'b1000, 1'b1, 2'd3, 8'hD0, 1'b1));
    vecs.push_back(mk(4'b1000, 4'b1000, 1'b1, 32'hD1000000, 4'b1000, 1'b1, 2'd3, 8'hD1, 1'b1));
    vecs.push_back(mk(4'b0000, 4'b0000, 1'b1, 32'h00000000, 4'b0000, 1'b0, 2'd3, 8'hD1, 1'b1));
    // Gap inside a lock: port3 pauses two cycles, port0 stays blocked.
    vecs.push_back(mk(4'b1000, 4'b0000, 1'b1, 32'hE0000000, 4'b1000, 1'b1, 2'd3, 8'hE0, 1'b0));
    vecs.push_back(mk(4'b0001, 4'b0001, 1'b1, 32'h000000F0, 4'b1000, 1'b0, 2'd3, 8'hE0, 1'b0));
    vecs.push_back(mk(4'b0001, 4'b0001, 1'b1, 32'h000000F0, 4'b1000, 1'b0, 2'd3, 8'hE0, 1'b0));
    vecs.push_back(mk(4'b1001, 4'b1001, 1'b1, 32'hE10000F0, 4'b1000, 1'b1, 2'd3, 8'hE1, 1'b1));
    vecs.push_back(mk(4'b0001, 4'b0001, 1'b1, 32'h000000F0, 4'b0001, 1'b1, 2'd0, 8'hF0, 1'b1));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-burst: port0 locked after beat 1, rr_ptr=1 before the reset.
    apply(mk(4'b0001, 4'b0000, 1'b1, 32'h00000050, 4'b0001, 1'b1, 2'd0, 8'h50, 1'b0), "rst beat1");
    @(negedge clock);
    i_valid = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst o_valid", 32'(o_valid), 32'd0);
    chk("midrst o_value", 32'(o_value), 32'd0);
    chk("midrst o_index", 32'(o_index), 32'd0);
    chk("midrst o_last",  32'(o_last),  32'd0);
    chk("midrst o_ready", 32'(o_ready), 32'd0);
    $display("midrst: o_valid=%b idx=%0d val=%h last=%b", o_valid, o_index, o_value, o_last);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    // Pointer back at 0 and lock dropped: port0 beats port1, then re-locks.
    apply(mk(4'b0011, 4'b0010, 1'b1, 32'h00007060, 4'b0001, 1'b1, 2'd0, 8'h60, 1'b0), "rearb b0");
    apply(mk(4'b0011, 4'b0010, 1'b1, 32'h00007061, 4'b0001, 1'b1, 2'd0, 8'h61, 1'b0), "rearb b1");
    apply(mk(4'b0011, 4'b0011, 1'b1, 32'h00007062, 4'b0001, 1'b1, 2'd0, 8'h62, 1'b1), "rearb b2");
    apply(mk(4'b0010, 4'b0010, 1'b1, 32'h00007000, 4'b0010, 1'b1, 2'd1, 8'h70, 1'b1), "rearb p1");
    @(negedge clock);
    i_valid = '0;

    // Three-port wrap: port2 alone first, then ports 2 and 0 alternate.
    exp3_idx = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2};
    exp3_rdy = '{3'b100, 3'b001, 3'b100, 3'b001, 3'b100};
    v3_value = {8'h32, 8'h31, 8'h30};
    v3_last  = 3'b111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      v3_valid = (i == 0) ? 3'b100 : 3'b101;
      #1;
      chk($sformatf("wrap%0d o_ready", i), 32'(o3_ready), 32'(exp3_rdy[i]));
      @(posedge clock);
      #1;
      chk($sformatf("wrap%0d o_valid", i), 32'(o3_valid), 32'd1);
      chk($sformatf("wrap%0d o_index", i), 32'(o3_index), 32'(exp3_idx[i]));
      chk($sformatf("wrap%0d o_value", i), 32'(o3_value), 32'h30 + 32'(exp3_idx[i]));
      $display("wrap%0d: valid=%b -> idx=%0d val=%h", i, v3_valid, o3_index, o3_value);
    end
    @(negedge clock);
    v3_valid = '0;
    @(posedge clock);
    #1;
    chk("wrap idle o_valid", 32'(o3_valid), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
